global_history_predictor: RTL and testbench

//  Next-generation correlating branch predictor: one pattern history table (PHT) of 2**index_width saturating counters,

---
 rtl/global_history_predictor.sv | 117 +++++++++++
 tb/tb_global_history_predictor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/global_history_predictor.sv
// Correlating branch predictor: one PHT of saturating counters indexed by the
// branch address folded with a global history register. Lookups return one
// cycle later; resolved outcomes train the PHT and shift the history.
module global_history_predictor #(
  parameter int address_width = 8,
  parameter int index_width   = 6,
  parameter int history_width = 4,
  parameter int counter_width = 2,
  parameter int mode          = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pred_valid,
  input  logic [address_width-1:0] pred_address,
  output logic                     pred_out_valid,
  output logic                     pred_taken,
  output logic [index_width-1:0]   pred_index,
  input  logic                     upd_valid,
  input  logic [index_width-1:0]   upd_index,
  input  logic                     upd_taken,
  input  logic                     upd_mispredict,
  output logic [history_width-1:0] ghr,
  output logic [15:0]              mispredict_count
);

  localparam int depth = 2 ** index_width;
  // Weakly not-taken: the largest value whose MSB is still clear.
  localparam logic [counter_width-1:0] ctr_init = counter_width'((2 ** (counter_width - 1)) - 1);
  localparam logic [counter_width-1:0] ctr_max  = '1;

  logic [counter_width-1:0] pht_q [depth];
  logic [history_width-1:0] ghr_q, ghr_d;
  logic [15:0]              mcount_q, mcount_d;
  logic                     pred_out_valid_q;
  logic                     pred_taken_q;
  logic [index_width-1:0]   pred_index_q;
  logic [counter_width-1:0] upd_ctr_d;
  logic [index_width-1:0]   addr_lo;
  logic [index_width-1:0]   lookup_idx;
  logic                     unused_addr;

  assign addr_lo     = pred_address[index_width-1:0];
  // Address bits above the index never reach the table.
  assign unused_addr = ^pred_address;

  generate
    if (mode == 1) begin : g_gselect
      if (history_width == index_width) begin : g_hist_only
        assign lookup_idx = ghr_q;
      end else begin : g_concat
        assign lookup_idx = {addr_lo[index_width-history_width-1:0], ghr_q};
      end
    end else if (mode == 2) begin : g_bimodal
      assign lookup_idx = addr_lo;
    end else begin : g_gshare
      assign lookup_idx = addr_lo ^ index_width'(ghr_q);
    end
  endgenerate

  // Next-state for the trained counter, the history shift and the miss counter.
  always_comb begin
    ghr_d     = ghr_q;
    mcount_d  = mcount_q;
    upd_ctr_d = pht_q[upd_index];
    if (upd_valid) begin
      ghr_d = (ghr_q << 1) | history_width'(upd_taken);
      if (upd_taken) begin
        if (upd_ctr_d != ctr_max) upd_ctr_d = upd_ctr_d + counter_width'(1);
      end else begin
        if (upd_ctr_d != '0) upd_ctr_d = upd_ctr_d - counter_width'(1);
      end
      if (upd_mispredict && (mcount_q != 16'hFFFF)) mcount_d = mcount_q + 16'd1;
    end
  end

  // PHT storage; a lookup in the same cycle still sees the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) pht_q[i] <= ctr_init;
    end else if (upd_valid) begin
      pht_q[upd_index] <= upd_ctr_d;
    end
  end

  // Global history and misprediction statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q    <= '0;
      mcount_q <= '0;
    end else begin
      ghr_q    <= ghr_d;
      mcount_q <= mcount_d;
    end
  end

  // Registered prediction; index and direction hold when no lookup is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_out_valid_q <= 1'b0;
      pred_taken_q     <= 1'b0;
      pred_index_q     <= '0;
    end else begin
      pred_out_valid_q <= pred_valid;
      if (pred_valid) begin
        pred_index_q <= lookup_idx;
        pred_taken_q <= pht_q[lookup_idx][counter_width-1];
      end
    end
  end

  assign pred_out_valid   = pred_out_valid_q;
  assign pred_taken       = pred_taken_q;
  assign pred_index       = pred_index_q;
  assign ghr              = ghr_q;
  assign mispredict_count = mcount_q;

endmodule

// File: tb/tb_global_history_predictor.sv
// Bench for global_history_predictor: three instances (gshare, gselect,
// bimodal) share all inputs and are compared against an array-based model.
module tb_global_history_predictor;

  localparam int IW = 6;
  localparam int HW = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst, pred_valid, upd_valid, upd_taken, upd_mispredict;
  logic [7:0]  pred_address;
  logic [5:0]  upd_index;
  logic [2:0]  pov, ptk;
  logic [2:0][5:0]  pix;
  logic [2:0][3:0]  gh;
  logic [2:0][15:0] mc;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int pht [64];
  int m_ghr, m_cnt;
  logic exp_valid;
  logic [2:0] exp_taken;
  int exp_idx [3];

  always #5 clk = ~clk;

  global_history_predictor #(.mode(0)) dut0 (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_address(pred_address),
    .pred_out_valid(pov[0]), .pred_taken(ptk[0]), .pred_index(pix[0]),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .ghr(gh[0]), .mispredict_count(mc[0]));

  global_history_predictor #(.mode(1)) dut1 (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_address(pred_address),
    .pred_out_valid(pov[1]), .pred_taken(ptk[1]), .pred_index(pix[1]),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .ghr(gh[1]), .mispredict_count(mc[1]));

  global_history_predictor #(.mode(2)) dut2 (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_address(pred_address),
    .pred_out_valid(pov[2]), .pred_taken(ptk[2]), .pred_index(pix[2]),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .ghr(gh[2]), .mispredict_count(mc[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_idx(input int m, input int addr, input int g);
    int a;
    a = addr % (2 ** IW);
    if (m == 0) return a ^ g;
    if (m == 1) return ((a % (2 ** (IW - HW))) * (2 ** HW)) + g;
    return a;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) pht[i] = (2 ** (CW - 1)) - 1;
    m_ghr = 0;
    m_cnt = 0;
  endtask

  task automatic chk_model();
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("m%0d_valid", m), 32'(pov[m]), 32'(exp_valid));
      chk($sformatf("m%0d_taken", m), 32'(ptk[m]), 32'(exp_taken[m]));
      chk($sformatf("m%0d_index", m), 32'(pix[m]), 32'(exp_idx[m]));
      chk($sformatf("m%0d_ghr", m), 32'(gh[m]), 32'(m_ghr));
      chk($sformatf("m%0d_count", m), 32'(mc[m]), 32'(m_cnt));
    end
  endtask

  // Advance one clock: evaluate the model on the inputs now applied, then
  // compare the DUT just after the edge.
  task automatic cycle(input bit do_check);
    int ix;
    if (rst) begin
      model_reset();
      exp_valid = 1'b0;
      exp_taken = '0;
      for (int m = 0; m < 3; m++) exp_idx[m] = 0;
    end else begin
      exp_valid = pred_valid;
      if (pred_valid) begin
        for (int m = 0; m < 3; m++) begin
          ix = model_idx(m, int'(pred_address), m_ghr);
          exp_idx[m]   = ix;
          exp_taken[m] = (pht[ix] >= 2 ** (CW - 1));
        end
      end
      if (upd_valid) begin
        if (upd_taken) begin
          if (pht[upd_index] < (2 ** CW) - 1) pht[upd_index]++;
        end else begin
          if (pht[upd_index] > 0) pht[upd_index]--;
        end
        m_ghr = ((m_ghr * 2) + int'(upd_taken)) % (2 ** HW);
        if (upd_mispredict && m_cnt < 65535) m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    if (do_check) chk_model();
  endtask

  task automatic idle();
    pred_valid = 0; upd_valid = 0; upd_taken = 0; upd_mispredict = 0; rst = 0;
  endtask

  task automatic upd(input int idx, input bit tk);
    idle();
    upd_valid = 1; upd_index = 6'(idx); upd_taken = tk;
    cycle(1);
  endtask

  task automatic pred(input int addr);
    idle();
    pred_valid = 1; pred_address = 8'(addr);
    cycle(1);
  endtask

  initial begin
    idle();
    pred_address = '0; upd_index = '0;
    model_reset();
    rst = 1;
    cycle(1);
    chk("rst_valid", 32'(pov[0]), 32'h0);
    chk("rst_ghr", 32'(gh[0]), 32'h0);

    // 1: first lookup after reset
    pred(8'h05);
    chk("t1_valid", 32'(pov[0]), 32'h1);
    chk("t1_index", 32'(pix[0]), 32'h05);
    chk("t1_taken", 32'(ptk[0]), 32'h0);
    chk("t1_count", 32'(mc[0]), 32'h0);
    idle(); cycle(1);
    chk("t1_idle_valid", 32'(pov[0]), 32'h0);
    chk("t1_hold_index", 32'(pix[0]), 32'h05);

    // 2: two taken updates, then gshare lookup lands on the same entry
    upd(6'h05, 1);
    upd(6'h05, 1);
    chk("t2_ghr", 32'(gh[0]), 32'h3);
    pred(8'h06);
    chk("t2_index", 32'(pix[0]), 32'h05);
    chk("t2_taken", 32'(ptk[0]), 32'h1);

    // 3: saturation at both ends
    for (int i = 0; i < 5; i++) upd(6'h10, 1);
    upd(6'h10, 0);
    pred(6'h10 ^ m_ghr);
    chk("t3_index", 32'(pix[0]), 32'h10);
    chk("t3_taken_after_dec", 32'(ptk[0]), 32'h1);
    upd(6'h10, 0);
    upd(6'h10, 0);
    pred(6'h10 ^ m_ghr);
    chk("t3_taken_at_zero", 32'(ptk[0]), 32'h0);
    upd(6'h10, 0);
    upd(6'h10, 1);
    pred(6'h10 ^ m_ghr);
    chk("t3_no_underflow", 32'(ptk[0]), 32'h0);

    // 4: read-before-write on a colliding predict + update
    upd(6'h05, 0);
    upd(6'h05, 0);
    idle();
    pred_valid = 1; pred_address = 8'(6'h05 ^ m_ghr);
    upd_valid = 1; upd_index = 6'h05; upd_taken = 1;
    cycle(1);
    chk("t4_index", 32'(pix[0]), 32'h05);
    chk("t4_taken_old", 32'(ptk[0]), 32'h0);
    pred(6'h05 ^ m_ghr);
    chk("t4_taken_new", 32'(ptk[0]), 32'h1);

    // 5: gselect and bimodal indexing with ghr = 5
    upd(6'h20, 0); upd(6'h20, 1); upd(6'h20, 0); upd(6'h20, 1);
    chk("t5_ghr", 32'(gh[1]), 32'h5);
    pred(8'hAB);
    chk("t5_gselect_index", 32'(pix[1]), 32'h35);
    chk("t5_bimodal_index", 32'(pix[2]), 32'h2B);

    // Randomised traffic with occasional resets and forced index collisions
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst            = ($urandom_range(0, 99) == 0);
      pred_valid     = $urandom_range(0, 1);
      pred_address   = 8'($urandom);
      upd_valid      = $urandom_range(0, 1);
      upd_taken      = $urandom_range(0, 1);
      upd_mispredict = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1)
        upd_index = 6'(model_idx(0, int'(pred_address), m_ghr));
      else
        upd_index = 6'($urandom);
      cycle(1);
    end

    // 6: miss counter saturation, then reset mid-lookup
    idle();
    upd_valid = 1; upd_mispredict = 1;
    for (int n = 0; n < 70000; n++) begin
      upd_index = 6'($urandom);
      upd_taken = $urandom_range(0, 1);
      cycle(0);
    end
    chk_model();
    chk("t6_count_sticks", 32'(mc[0]), 32'hFFFF);
    idle();
    rst = 1; pred_valid = 1; pred_address = 8'h12;
    upd_valid = 1; upd_index = 6'h12; upd_taken = 1; upd_mispredict = 1;
    cycle(1);
    chk("t6_rst_valid", 32'(pov[0]), 32'h0);
    chk("t6_rst_count", 32'(mc[0]), 32'h0);
    chk("t6_rst_ghr", 32'(gh[0]), 32'h0);
    for (int i = 0; i < 64; i++) begin
      pred(i);
      chk($sformatf("t6_weak_nt_%0d", i), 32'(ptk[2]), 32'h0);
    end
    // Weakly (not strongly) not-taken: one taken update flips the prediction.
    upd(6'h12, 1);
    pred(8'h12);
    chk("t6_weak_flip", 32'(ptk[2]), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
